// File: rtl/onehot_addr_guard.sv
// Hardened address decoder: binary address -> one-hot select, preserved buffer stage,
// and an independent re-check of the buffered vector with a sticky error flag.
module onehot_addr_guard #(
  parameter int AddrWidth   = 5,
  parameter int OneHotWidth = 32,
  parameter bit AddrCheck   = 1'b1,
  parameter bit EnableCheck = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   en_i,
  input  logic [OneHotWidth-1:0] fault_i,
  input  logic                   err_clr_i,
  output logic [OneHotWidth-1:0] oh_o,
  output logic                   err_o,
  output logic                   err_sticky_o
);

  if (OneHotWidth > (1 << AddrWidth) || OneHotWidth < 2) begin : g_param_check
    $error("onehot_addr_guard: OneHotWidth must lie in 2..2**AddrWidth");
  end

  logic [OneHotWidth-1:0] enc;
  (* keep = "true", dont_touch = "true" *) logic [OneHotWidth-1:0] sel_buf;

  always_comb begin
    enc = '0;
    for (int i = 0; i < OneHotWidth; i++) begin
      enc[i] = en_i && (addr_i == AddrWidth'(i));
    end
  end

  assign sel_buf = enc;
  assign oh_o    = sel_buf ^ fault_i;

  // The checker looks only at oh_o and the raw inputs, never at enc, so a fault
  // anywhere between encoder and output is visible.
  logic any_set;
  logic multi_set;
  logic seen;
  logic sel_at_addr;
  logic onehot_err;
  logic addr_err;
  logic en_err;

  always_comb begin
    seen        = 1'b0;
    multi_set   = 1'b0;
    sel_at_addr = 1'b0;
    for (int i = 0; i < OneHotWidth; i++) begin
      multi_set   = multi_set | (seen & oh_o[i]);
      seen        = seen | oh_o[i];
      sel_at_addr = sel_at_addr | (oh_o[i] & (addr_i == AddrWidth'(i)));
    end
    any_set    = seen;
    onehot_err = multi_set;
    addr_err   = AddrCheck && any_set && !sel_at_addr;
    en_err     = EnableCheck && (en_i != any_set);
    err_o      = onehot_err | addr_err | en_err;
  end

  logic err_sticky_q;
  logic err_sticky_d;

  // A clear in a cycle that still has an error re-arms the flag immediately.
  assign err_sticky_d = err_clr_i ? err_o : (err_sticky_q | err_o);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_onehot_addr_guard.sv
// Bench for onehot_addr_guard: default instance plus AddrCheck=0 and OneHotWidth=20
// variants, checked against constant vectors and a behavioural model.
module tb_onehot_addr_guard;

  logic        clk;
  logic        rst;
  logic [4:0]  addr;
  logic        en;
  logic [31:0] fault;
  logic        clr;

  logic [31:0] oh_m, oh_na;
  logic [19:0] oh_w;
  logic        err_m, err_na, err_w;
  logic        st_m, st_na, st_w;

  int n_cmp  = 0;
  int n_fail = 0;

  bit exp_st_m, exp_st_na, exp_st_w;
  bit exp_err_m, exp_err_na, exp_err_w;

  onehot_addr_guard dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .en_i(en), .fault_i(fault),
    .err_clr_i(clr), .oh_o(oh_m), .err_o(err_m), .err_sticky_o(st_m)
  );

  onehot_addr_guard #(.AddrCheck(1'b0)) dut_na (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .en_i(en), .fault_i(fault),
    .err_clr_i(clr), .oh_o(oh_na), .err_o(err_na), .err_sticky_o(st_na)
  );

  onehot_addr_guard #(.OneHotWidth(20)) dut_w20 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .en_i(en), .fault_i(fault[19:0]),
    .err_clr_i(clr), .oh_o(oh_w), .err_o(err_w), .err_sticky_o(st_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic        en;
    logic [31:0] fault;
    logic [31:0] exp_oh;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (addr=%0d en=%0b fault=%h)",
               name, act, exp, addr, en, fault);
    end
  endtask

  // Reference: ideal select for a w-line decoder, then the fault mask, then the rules.
  function automatic void model(input int w, input bit achk, input int a, input bit e,
                                input logic [31:0] f, output logic [31:0] oh, output bit err);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    oh   = ((e && a < w) ? (32'd1 << a) : 32'd0) ^ (f & mask);
    err  = ($countones(oh) > 1);
    if (achk && oh != 0 && (a >= w || oh[a] == 1'b0)) err = 1'b1;
    if (e != (oh != 0)) err = 1'b1;
  endfunction

  task automatic drive(input int a, input bit e, input logic [31:0] f, input bit c);
    @(negedge clk);
    addr  = 5'(a);
    en    = e;
    fault = f;
    clr   = c;
    #1;
  endtask

  task automatic comb_check();
    logic [31:0] oh;
    bit er;
    model(32, 1'b1, int'(addr), en, fault, oh, er);
    check("oh_main", oh_m, oh);
    check("err_main", {31'd0, err_m}, {31'd0, er});
    exp_err_m = er;
    model(32, 1'b0, int'(addr), en, fault, oh, er);
    check("oh_noaddr", oh_na, oh);
    check("err_noaddr", {31'd0, err_na}, {31'd0, er});
    exp_err_na = er;
    model(20, 1'b1, int'(addr), en, fault, oh, er);
    check("oh_w20", {12'd0, oh_w}, oh);
    check("err_w20", {31'd0, err_w}, {31'd0, er});
    exp_err_w = er;
  endtask

  task automatic tick();
    @(posedge clk);
    exp_st_m  = clr ? exp_err_m  : (exp_st_m  | exp_err_m);
    exp_st_na = clr ? exp_err_na : (exp_st_na | exp_err_na);
    exp_st_w  = clr ? exp_err_w  : (exp_st_w  | exp_err_w);
    #1;
    check("sticky_main", {31'd0, st_m}, {31'd0, exp_st_m});
    check("sticky_noaddr", {31'd0, st_na}, {31'd0, exp_st_na});
    check("sticky_w20", {31'd0, st_w}, {31'd0, exp_st_w});
  endtask

  task automatic step(input int a, input bit e, input logic [31:0] f, input bit c);
    drive(a, e, f, c);
    comb_check();
    tick();
  endtask

  initial begin
    vecs[0] = '{5'd7,  1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1] = '{5'd7,  1'b0, 32'h0000_0010, 32'h0000_0010, 1'b1};
    vecs[2] = '{5'd3,  1'b1, 32'h0000_0100, 32'h0000_0108, 1'b1};
    vecs[3] = '{5'd5,  1'b1, 32'h0000_0060, 32'h0000_0040, 1'b1};
    vecs[4] = '{5'd2,  1'b1, 32'h0000_0004, 32'h0000_0000, 1'b1};
    vecs[5] = '{5'd31, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{5'd0,  1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[7] = '{5'd0,  1'b0, 32'h0000_0003, 32'h0000_0003, 1'b1};

    rst = 1'b1; addr = '0; en = 1'b0; fault = '0; clr = 1'b0;
    exp_st_m = 0; exp_st_na = 0; exp_st_w = 0;
    #12;
    check("reset_sticky_main", {31'd0, st_m}, 32'd0);
    check("reset_sticky_w20", {31'd0, st_w}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean sweep: main and AddrCheck=0 instances never flag.
    for (int a = 0; a < 32; a++) begin
      drive(a, 1'b1, 32'd0, 1'b0);
      check("sweep_oh", oh_m, 32'd1 << a);
      check("sweep_err", {31'd0, err_m}, 32'd0);
      comb_check();
      tick();
      check("sweep_sticky", {31'd0, st_m}, 32'd0);
    end

    // Out-of-range address on the 20-line instance.
    drive(25, 1'b1, 32'd0, 1'b0);
    check("w20_oor_oh", {12'd0, oh_w}, 32'd0);
    check("w20_oor_err", {31'd0, err_w}, 32'd1);
    comb_check();
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(int'(vecs[i].addr), vecs[i].en, vecs[i].fault, 1'b0);
      check("vec_oh", oh_m, vecs[i].exp_oh);
      check("vec_err", {31'd0, err_m}, {31'd0, vecs[i].exp_err});
      if (i == 3) check("vec_noaddr_err", {31'd0, err_na}, 32'd0);
      comb_check();
      tick();
    end

    // Double-hot sets the flag, which then holds once the fault is gone.
    step(0, 1'b1, 32'd0, 1'b1);
    check("clear_clean", {31'd0, st_m}, 32'd0);
    step(3, 1'b1, 32'h0000_0100, 1'b0);
    check("double_hot_set", {31'd0, st_m}, 32'd1);
    step(3, 1'b1, 32'd0, 1'b0);
    check("double_hot_hold", {31'd0, st_m}, 32'd1);
    step(4, 1'b1, 32'h0000_0001, 1'b1);
    check("clear_with_err", {31'd0, st_m}, 32'd1);
    step(4, 1'b1, 32'd0, 1'b1);
    check("clear_no_err", {31'd0, st_m}, 32'd0);

    // Asynchronous reset between edges, then accumulation resumes after release.
    step(9, 1'b1, 32'h0000_0002, 1'b0);
    check("pre_reset_set", {31'd0, st_m}, 32'd1);
    drive(9, 1'b1, 32'h0000_0002, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_main", {31'd0, st_m}, 32'd0);
    check("async_rst_noaddr", {31'd0, st_na}, 32'd0);
    check("async_rst_w20", {31'd0, st_w}, 32'd0);
    rst = 1'b0;
    exp_st_m = 0; exp_st_na = 0; exp_st_w = 0;
    comb_check();
    tick();
    check("post_rst_accum", {31'd0, st_m}, 32'd1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] f;
      case ($urandom_range(0, 3))
        0, 3: f = 32'd0;
        1:    f = 32'd1 << $urandom_range(0, 31);
        default: f = $urandom;
      endcase
      step(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), f,
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
